ring_out_arbiter: RTL and testbench

- Per-output-port scheduler for the gold ring router.
- Shares one outgoing ring link between two requesters: requester 0 is the upstream ring input (pass-through) and requester 1 is the local NIC injection port.
- Keeps one single-flit output buffer per virtual channel (VC0/VC1). Uses the even/odd polarity phase so that the buffer being filled and the buffer being drained are never the same one in a given cycle.
- Round-robin fairness is applied per VC.

---
 rtl/ring_pkg.sv | 17 +
 rtl/ring_out_arbiter_rr_arb2.sv | 31 +++
 rtl/ring_out_arbiter.sv | 104 ++++++++++
 tb/tb_ring_out_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared constants and flit layout for the gold ring router.
// The VC bit lives at the top of the flit; direction and hop count sit just below it.
package ring_pkg;

    localparam int DATA_W   = 64;
    localparam int VC_BIT   = 63;
    localparam int REQ_RING = 0;
    localparam int REQ_PE   = 1;

    typedef struct packed {
        logic        vc;
        logic        dir;
        logic [5:0]  hop;
        logic [55:0] payload;
    } flit_hdr_t;

endpackage

// File: rtl/ring_out_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, zero when nothing requests.
// The priority pointer moves to the other input only when an update is enabled and a grant occurs.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    output logic [1:0] o_gnt
);

    logic r_prio;

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_prio ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

    // Winning input 0 hands priority to input 1, and vice versa.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_prio <= 1'b0;
        else if (i_upd && (|o_gnt))
            r_prio <= o_gnt[0];
    end

endmodule

// File: rtl/ring_out_arbiter.sv
// Output-port scheduler: ring pass-through and NIC injection share one link via two single-flit VC buffers.
// Polarity p lets only VC p fill and only VC ~p drain, so a buffer is never read and written in one cycle.
module ring_out_arbiter
    import ring_pkg::*;
#(
    parameter int DATA_W = ring_pkg::DATA_W,
    parameter int VC_BIT = ring_pkg::VC_BIT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_si,
    input  logic [DATA_W-1:0] req0_di,
    output logic              req0_ri,
    input  logic              req1_si,
    input  logic [DATA_W-1:0] req1_di,
    output logic              req1_ri,
    output logic              out_so,
    output logic [DATA_W-1:0] out_do,
    input  logic              out_ri,
    output logic              polarity,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    logic              r_pol;
    logic [1:0]        r_full;
    logic [DATA_W-1:0] r_ob [2];
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_drain;
    logic              w_elig0;
    logic              w_elig1;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt_vc0;
    logic [1:0]        w_gnt_vc1;
    logic [1:0]        w_gnt;
    logic [DATA_W-1:0] w_fill_dat;

    assign w_drain = ~r_pol;

    // A flit is eligible only in the phase matching its VC and only while that buffer is empty.
    assign w_elig0 = req0_si & (req0_di[VC_BIT] == r_pol) & ~r_full[r_pol];
    assign w_elig1 = req1_si & (req1_di[VC_BIT] == r_pol) & ~r_full[r_pol];
    assign w_req   = {w_elig1, w_elig0};

    rr_arb2 u_arb_vc0 (
        .clk   (clk),
        .reset (reset),
        .i_req (r_pol ? 2'b00 : w_req),
        .i_upd (~r_pol),
        .o_gnt (w_gnt_vc0)
    );

    rr_arb2 u_arb_vc1 (
        .clk   (clk),
        .reset (reset),
        .i_req (r_pol ? w_req : 2'b00),
        .i_upd (r_pol),
        .o_gnt (w_gnt_vc1)
    );

    assign w_gnt      = w_gnt_vc0 | w_gnt_vc1;
    assign req0_ri    = w_gnt[REQ_RING];
    assign req1_ri    = w_gnt[REQ_PE];
    assign w_fill_dat = w_gnt[REQ_PE] ? req1_di : req0_di;

    assign out_so     = r_full[w_drain];
    assign out_do     = r_full[w_drain] ? r_ob[w_drain] : '0;
    assign polarity   = r_pol;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pol  <= 1'b0;
            r_full <= 2'b00;
            r_ob[0] <= '0;
            r_ob[1] <= '0;
        end else begin
            r_pol <= ~r_pol;
            if (out_so && out_ri)
                r_full[w_drain] <= 1'b0;
            if (|w_gnt) begin
                r_full[r_pol] <= 1'b1;
                r_ob[r_pol]   <= w_fill_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt[REQ_RING] && (r_cnt0 != '1))
                r_cnt0 <= r_cnt0 + 1'b1;
            if (w_gnt[REQ_PE] && (r_cnt1 != '1))
                r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_ring_out_arbiter.sv
// Bench for ring_out_arbiter: directed vector table, hand-written corner sequences, then random traffic
// against a cycle-level model; a second instance with 2-bit counters exposes saturation quickly.
module tb_ring_out_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_si, req1_si, out_ri;
    logic [63:0] req0_di, req1_di;
    logic        req0_ri, req1_ri, out_so, polarity;
    logic [63:0] out_do;
    logic [15:0] grant_cnt0, grant_cnt1;

    logic        s_r0, s_r1, s_so, s_pol;
    logic [63:0] s_do;
    logic [1:0]  s_c0, s_c1;

    int total = 0;
    int bad   = 0;

    ring_out_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_si(req0_si), .req0_di(req0_di), .req0_ri(req0_ri),
        .req1_si(req1_si), .req1_di(req1_di), .req1_ri(req1_ri),
        .out_so(out_so), .out_do(out_do), .out_ri(out_ri),
        .polarity(polarity), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    ring_out_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .req0_si(req0_si), .req0_di(req0_di), .req0_ri(s_r0),
        .req1_si(req1_si), .req1_di(req1_di), .req1_ri(s_r1),
        .out_so(s_so), .out_do(s_do), .out_ri(out_ri),
        .polarity(s_pol), .grant_cnt0(s_c0), .grant_cnt1(s_c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        a_si;
        logic [63:0] a_di;
        logic        b_si;
        logic [63:0] b_di;
        logic        o_ri;
        logic        e_r0;
        logic        e_r1;
        logic        e_so;
        logic [63:0] e_do;
        logic        e_pol;
        int          e_c0;
        int          e_c1;
    } vec_t;

    vec_t tbl [17];

    localparam logic [63:0] V1A = 64'h8000_0000_0000_0001;
    localparam logic [63:0] V1B = 64'h8000_0000_0000_0002;
    localparam logic [63:0] V1C = 64'h8000_0000_0000_0003;
    localparam logic [63:0] A5  = 64'h0000_0000_0000_00A5;
    localparam logic [63:0] BX  = 64'h0000_0000_0000_0BB1;
    localparam logic [63:0] BY  = 64'h0000_0000_0000_0CC2;

    function automatic vec_t mk(input logic a, input logic [63:0] ad, input logic b, input logic [63:0] bd,
                                input logic ori, input logic r0, input logic r1, input logic so,
                                input logic [63:0] dd, input logic pl, input int c0, input int c1);
        vec_t v;
        v.a_si = a;  v.a_di = ad; v.b_si = b;  v.b_di = bd; v.o_ri = ori;
        v.e_r0 = r0; v.e_r1 = r1; v.e_so = so; v.e_do = dd; v.e_pol = pl;
        v.e_c0 = c0; v.e_c1 = c1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic [63:0] ad, input logic b, input logic [63:0] bd,
                         input logic ori);
        req0_si = a; req0_di = ad; req1_si = b; req1_di = bd; out_ri = ori;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge, with reset released and polarity 0.
    task automatic rst_dut();
        drive(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Reference model state: buffer contents, who holds priority per VC, transfer counts.
    int          m_pol;
    bit          m_full [2];
    logic [63:0] m_ob [2];
    int          m_pri [2];
    int          m_cnt [2];

    bit          hold [2];
    logic [63:0] hd [2];

    initial begin
        reset = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);

        tbl[0]  = mk(0, 0,   0, 0,   1, 0, 0, 0, 0,   0, 0, 0);
        tbl[1]  = mk(0, 0,   0, 0,   1, 0, 0, 0, 0,   1, 0, 0);
        tbl[2]  = mk(0, 0,   0, 0,   1, 0, 0, 0, 0,   0, 0, 0);
        tbl[3]  = mk(0, 0,   0, 0,   1, 0, 0, 0, 0,   1, 0, 0);
        tbl[4]  = mk(1, V1A, 1, V1B, 1, 0, 0, 0, 0,   0, 0, 0);
        tbl[5]  = mk(1, V1A, 1, V1B, 1, 1, 0, 0, 0,   1, 0, 0);
        tbl[6]  = mk(1, V1A, 1, V1B, 1, 0, 0, 1, V1A, 0, 1, 0);
        tbl[7]  = mk(1, V1A, 1, V1B, 1, 0, 1, 0, 0,   1, 1, 0);
        tbl[8]  = mk(1, V1A, 1, V1B, 1, 0, 0, 1, V1B, 0, 1, 1);
        tbl[9]  = mk(1, V1A, 1, V1B, 1, 1, 0, 0, 0,   1, 1, 1);
        tbl[10] = mk(0, 0,   0, 0,   1, 0, 0, 1, V1A, 0, 2, 1);
        tbl[11] = mk(0, 0,   0, 0,   1, 0, 0, 0, 0,   1, 2, 1);
        tbl[12] = mk(0, 0,   1, A5,  1, 0, 1, 0, 0,   0, 2, 1);
        tbl[13] = mk(0, 0,   0, 0,   1, 0, 0, 1, A5,  1, 2, 2);
        tbl[14] = mk(1, V1C, 0, 0,   1, 0, 0, 0, 0,   0, 2, 2);
        tbl[15] = mk(1, V1C, 0, 0,   1, 1, 0, 0, 0,   1, 2, 2);
        tbl[16] = mk(0, 0,   0, 0,   1, 0, 0, 1, V1C, 0, 3, 2);

        // Directed table: idle after reset, contention on VC1, single flit, wrong-phase request.
        rst_dut();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].a_si, tbl[i].a_di, tbl[i].b_si, tbl[i].b_di, tbl[i].o_ri);
            @(negedge clk);
            chk($sformatf("row%0d_r0", i),  req0_ri,    tbl[i].e_r0);
            chk($sformatf("row%0d_r1", i),  req1_ri,    tbl[i].e_r1);
            chk($sformatf("row%0d_so", i),  out_so,     tbl[i].e_so);
            chk($sformatf("row%0d_do", i),  out_do,     tbl[i].e_do);
            chk($sformatf("row%0d_pol", i), polarity,   tbl[i].e_pol);
            chk($sformatf("row%0d_c0", i),  grant_cnt0, 64'(tbl[i].e_c0));
            chk($sformatf("row%0d_c1", i),  grant_cnt1, 64'(tbl[i].e_c1));
            if (i < 16) step();
        end
        chk("sat_cnt0_top", s_c0, 64'd3);

        // Backpressure: ob[0] held for several cycles while a VC0 flit waits.
        rst_dut();
        drive(1, BX, 0, 0, 1);
        @(negedge clk);
        chk("bp_accept_r0", req0_ri, 1);
        step();
        drive(0, 0, 1, BY, 0);
        @(negedge clk);
        chk("bp_first_so", out_so, 1);
        chk("bp_first_do", out_do, BX);
        chk("bp_first_r1", req1_ri, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            chk($sformatf("bp_hold%0d_r1", k), req1_ri, 0);
            if (k % 2 == 1) begin
                chk($sformatf("bp_hold%0d_so", k), out_so, 1);
                chk($sformatf("bp_hold%0d_do", k), out_do, BX);
            end
        end
        step();
        out_ri = 1'b1;
        @(negedge clk);
        chk("bp_even_r1", req1_ri, 0);
        step();
        @(negedge clk);
        chk("bp_drain_so", out_so, 1);
        chk("bp_drain_do", out_do, BX);
        chk("bp_drain_r1", req1_ri, 0);
        step();
        @(negedge clk);
        chk("bp_pending_r1", req1_ri, 1);
        step();
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("bp_out_so", out_so, 1);
        chk("bp_out_do", out_do, BY);
        chk("bp_cnt0", grant_cnt0, 1);
        chk("bp_cnt1", grant_cnt1, 1);

        // Asynchronous reset with both buffers full.
        rst_dut();
        drive(1, 64'h0000_0000_0000_D000, 0, 0, 0);
        @(negedge clk);
        chk("ar_fill0_r0", req0_ri, 1);
        step();
        drive(1, 64'h8000_0000_0000_D001, 0, 0, 0);
        @(negedge clk);
        chk("ar_fill1_r0", req0_ri, 1);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("ar_full_so", out_so, 1);
        chk("ar_full_do", out_do, 64'h8000_0000_0000_D001);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_now_so", out_so, 0);
        chk("ar_now_do", out_do, 0);
        chk("ar_now_pol", polarity, 0);
        chk("ar_now_cnt0", grant_cnt0, 0);
        reset = 1'b1;
        out_ri = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            chk($sformatf("ar_after%0d_so", k), out_so, 0);
        end

        // Random traffic against the model.
        rst_dut();
        m_pol = 0;
        for (int r = 0; r < 2; r++) begin
            m_full[r] = 0; m_ob[r] = '0; m_pri[r] = 0; m_cnt[r] = 0;
            hold[r] = 0; hd[r] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            int   p, g;
            bit   el [2];
            logic ori, e_so;
            logic [63:0] e_do;
            for (int r = 0; r < 2; r++)
                if (!hold[r] && $urandom_range(0, 99) < 55) begin
                    hold[r] = 1;
                    hd[r]   = {$urandom, $urandom};
                end
            ori = ($urandom_range(0, 99) < 65);
            drive(hold[0], hd[0], hold[1], hd[1], ori);

            p    = m_pol;
            e_so = m_full[1-p];
            e_do = e_so ? m_ob[1-p] : 64'd0;
            for (int r = 0; r < 2; r++)
                el[r] = hold[r] && (int'(hd[r][63]) == p) && !m_full[p];
            if (el[0] && el[1]) g = m_pri[p];
            else if (el[0])     g = 0;
            else if (el[1])     g = 1;
            else                g = -1;

            @(negedge clk);
            chk("rnd_r0",   req0_ri,  (g == 0));
            chk("rnd_r1",   req1_ri,  (g == 1));
            chk("rnd_so",   out_so,   e_so);
            chk("rnd_do",   out_do,   e_do);
            chk("rnd_pol",  polarity, p[0]);
            chk("rnd_cnt0", grant_cnt0, 64'(m_cnt[0]));
            chk("rnd_cnt1", grant_cnt1, 64'(m_cnt[1]));
            chk("rnd_sat0", s_c0, 64'((m_cnt[0] > 3) ? 3 : m_cnt[0]));
            chk("rnd_sat1", s_c1, 64'((m_cnt[1] > 3) ? 3 : m_cnt[1]));
            chk("rnd_sat_link", {s_r0, s_r1, s_so, s_pol}, {(g == 0), (g == 1), e_so, p[0]});
            chk("rnd_sat_do", s_do, e_do);

            if (e_so && ori) m_full[1-p] = 0;
            if (g >= 0) begin
                m_ob[p]   = hd[g];
                m_full[p] = 1;
                m_pri[p]  = 1 - g;
                if (m_cnt[g] < 65535) m_cnt[g]++;
                hold[g]   = 0;
            end
            m_pol = 1 - p;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
